// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings, master FSM states, slave register map and lane helpers.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HSIZE_HALF    = 3'd1;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;
  localparam logic [3:0] REG_BUF       = 4'h0;
  localparam logic [3:0] REG_STATUS    = 4'h4;
  localparam logic [3:0] REG_ERROR     = 4'h6;
  localparam logic [3:0] REG_OCC       = 4'h8;
  localparam logic [3:0] REG_TXCTL     = 4'hC;
  localparam logic [3:0] REG_FLUSH     = 4'hD;
  typedef enum logic [1:0] {IDLE, RUN, ERR} state_e;
  function automatic logic [31:0] size_mask(input logic [1:0] size);
    return size == 2'd0 ? 32'h0000_00FF : size == 2'd1 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == 2'd3 || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);
  endfunction
endpackage

// File: rtl/ahb_lite_master_if.sv
// ahb_lite_master_if: AHB-Lite bus signals between the master and the slave register map.
interface ahb_lite_master_if #(parameter int ADDR_WIDTH = 4) ();
  logic [ADDR_WIDTH-1:0] haddr;
  logic [2:0] hsize;
  logic [1:0] htrans;
  logic hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic hready;
  logic hresp;
  modport master (output haddr, hsize, htrans, hwrite, hwdata, input hrdata, hready, hresp);
  modport slave (input haddr, hsize, htrans, hwrite, hwdata, output hrdata, hready, hresp);
endinterface

// File: rtl/ahb_byte_lane.sv
// ahb_byte_lane: places write data on byte lanes and extracts/masks read data.
module ahb_byte_lane import ahb_pkg::*; (
  input  logic [1:0]  wr_size,
  input  logic [1:0]  wr_off,
  input  logic [31:0] wr_data,
  output logic [31:0] wr_lanes,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_off,
  input  logic [31:0] rd_bus,
  output logic [31:0] rd_data
);
  assign wr_lanes = (wr_data & size_mask(wr_size)) << {wr_off, 3'b000};
  assign rd_data = (rd_bus >> {rd_off, 3'b000}) & size_mask(rd_size);
endmodule

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: two-slot pipelined AHB-Lite initiator with in-order responses.
module ahb_lite_master import ahb_pkg::*; #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [1:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  ahb_lite_master_if.master     bus
);
  state_e state_q, state_d;
  logic a_valid_q, a_valid_d, a_write_q, a_write_d;
  logic [1:0] a_size_q, a_size_d;
  logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
  logic [31:0] a_wdata_q, a_wdata_d;
  logic d_valid_q, d_valid_d, d_write_q, d_write_d;
  logic [1:0] d_size_q, d_size_d, d_off_q, d_off_d;
  logic [1:0] htrans_q, htrans_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic cancel_q, cancel_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic mis, acc, err_start;
  logic [31:0] wr_lanes, rd_data;
  ahb_byte_lane u_lane (
    .wr_size(cmd_size), .wr_off(cmd_addr[1:0]), .wr_data(cmd_wdata), .wr_lanes(wr_lanes),
    .rd_size(d_size_q), .rd_off(d_off_q), .rd_bus(bus.hrdata), .rd_data(rd_data)
  );
  assign mis = misaligned(cmd_size, cmd_addr[1:0]);
  // Illegal commands only enter an empty pipeline so their error response stays in order.
  assign cmd_ready = !rst && state_q != ERR && (!a_valid_q || bus.hready) && !cancel_q &&
                     (!mis || (!a_valid_q && !d_valid_q));
  assign acc = cmd_valid && cmd_ready;
  assign err_start = state_q != ERR && d_valid_q && bus.hresp && !bus.hready;
  always_comb begin
    a_valid_d = a_valid_q;
    a_write_d = a_write_q;
    a_size_d = a_size_q;
    a_addr_d = a_addr_q;
    a_wdata_d = a_wdata_q;
    d_valid_d = d_valid_q;
    d_write_d = d_write_q;
    d_size_d = d_size_q;
    d_off_d = d_off_q;
    hwdata_d = hwdata_q;
    cancel_d = cancel_q;
    rsp_valid_d = 1'b0;
    rsp_err_d = 1'b0;
    rsp_rdata_d = '0;
    if (bus.hready) begin
      d_valid_d = a_valid_q;
      d_write_d = a_write_q;
      d_size_d = a_size_q;
      d_off_d = a_addr_q[1:0];
      a_valid_d = 1'b0;
      hwdata_d = (a_valid_q && a_write_q) ? a_wdata_q : hwdata_q;
      if (d_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_err_d = bus.hresp || state_q == ERR;
        rsp_rdata_d = (d_write_q || rsp_err_d) ? '0 : rd_data;
      end
    end
    if (cancel_q && state_q != ERR) begin
      rsp_valid_d = 1'b1;
      rsp_err_d = 1'b1;
      cancel_d = 1'b0;
    end
    if (acc && mis) begin
      rsp_valid_d = 1'b1;
      rsp_err_d = 1'b1;
    end
    if (acc && !mis) begin
      a_valid_d = 1'b1;
      a_write_d = cmd_write;
      a_size_d = cmd_size;
      a_addr_d = cmd_addr;
      a_wdata_d = wr_lanes;
    end
    // First error cycle: whatever sits in the address phase is pulled off the bus.
    if (err_start) begin
      cancel_d = a_valid_d;
      a_valid_d = 1'b0;
    end
    htrans_d = a_valid_d ? HTRANS_NONSEQ : HTRANS_IDLE;
    state_d = (a_valid_d || d_valid_d || cancel_d) ? RUN : IDLE;
    state_d = (err_start || (state_q == ERR && !bus.hready)) ? ERR : state_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_valid_q <= 1'b0;
      a_write_q <= 1'b0;
      a_size_q <= '0;
      a_addr_q <= '0;
      a_wdata_q <= '0;
      d_valid_q <= 1'b0;
      d_write_q <= 1'b0;
      d_size_q <= '0;
      d_off_q <= '0;
      htrans_q <= HTRANS_IDLE;
      hwdata_q <= '0;
      cancel_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      a_valid_q <= a_valid_d;
      a_write_q <= a_write_d;
      a_size_q <= a_size_d;
      a_addr_q <= a_addr_d;
      a_wdata_q <= a_wdata_d;
      d_valid_q <= d_valid_d;
      d_write_q <= d_write_d;
      d_size_q <= d_size_d;
      d_off_q <= d_off_d;
      htrans_q <= htrans_d;
      hwdata_q <= hwdata_d;
      cancel_q <= cancel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
  assign bus.haddr = a_addr_q;
  assign bus.hsize = {1'b0, a_size_q};
  assign bus.htrans = htrans_q;
  assign bus.hwrite = a_write_q;
  assign bus.hwdata = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed cycle-by-cycle checks of bus timing, lanes, stalls, errors and reset.
module tb_ahb_lite_master;
  import ahb_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr;
  logic [1:0] cmd_size;
  logic [31:0] cmd_wdata;
  logic rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int n_chk = 0;
  int n_pass = 0;
  ahb_lite_master_if #(.ADDR_WIDTH(4)) bus ();
  ahb_lite_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic cmd(input logic v, input logic w, input logic [3:0] a, input logic [1:0] s, input logic [31:0] d);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr = a;
    cmd_size = s;
    cmd_wdata = d;
  endtask
  task automatic nxt;
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1;
    bus.hready = 1'b1;
    bus.hresp = 1'b0;
    bus.hrdata = '0;
    cmd(0, 0, 4'h0, 2'd0, 32'h0);
    repeat (2) nxt();
    #1;
    chk("rst_htrans", bus.htrans, HTRANS_IDLE);
    chk("rst_haddr", bus.haddr, 0);
    chk("rst_hwrite", bus.hwrite, 0);
    chk("rst_hwdata", bus.hwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    // Word write, zero wait states
    nxt(); cmd(1, 1, REG_BUF, 2'd2, 32'hDEADBEEF); #1;
    chk("wr_ready", cmd_ready, 1);
    nxt(); cmd(0, 0, 4'h0, 2'd0, 32'h0); #1;
    chk("wr_c1_htrans", bus.htrans, HTRANS_NONSEQ);
    chk("wr_c1_haddr", bus.haddr, 4'h0);
    chk("wr_c1_hwrite", bus.hwrite, 1);
    chk("wr_c1_hsize", bus.hsize, HSIZE_WORD);
    nxt(); #1;
    chk("wr_c2_hwdata", bus.hwdata, 32'hDEADBEEF);
    chk("wr_c2_rsp_valid", rsp_valid, 0);
    chk("wr_c2_htrans", bus.htrans, HTRANS_IDLE);
    nxt(); #1;
    chk("wr_c3_rsp_valid", rsp_valid, 1);
    chk("wr_c3_rsp_err", rsp_err, 0);
    chk("wr_c3_rsp_rdata", rsp_rdata, 0);
    nxt(); #1;
    chk("wr_c4_rsp_valid", rsp_valid, 0);
    // Byte read of 0x5 takes lane 1
    cmd(1, 0, 4'h5, 2'd0, 32'h0); #1;
    nxt(); cmd(0, 0, 4'h0, 2'd0, 32'h0); #1;
    chk("rdb_hsize", bus.hsize, HSIZE_BYTE);
    chk("rdb_haddr", bus.haddr, 4'h5);
    nxt(); bus.hrdata = 32'h00AB_CD00; #1;
    nxt(); #1;
    chk("rdb_rsp_valid", rsp_valid, 1);
    chk("rdb_rsp_rdata", rsp_rdata, 32'h0000_00CD);
    // Half read of 0x6 takes lanes 2-3
    nxt(); cmd(1, 0, REG_ERROR, 2'd1, 32'h0); #1;
    nxt(); cmd(0, 0, 4'h0, 2'd0, 32'h0); #1;
    chk("rdh_hsize", bus.hsize, HSIZE_HALF);
    nxt(); bus.hrdata = 32'h00AB_CD00; #1;
    nxt(); #1;
    chk("rdh_rsp_rdata", rsp_rdata, 32'h0000_00AB);
    // Half write to 0x6: upper command bits are masked off
    nxt(); cmd(1, 1, REG_ERROR, 2'd1, 32'hFFFF_1234); #1;
    nxt(); cmd(0, 0, 4'h0, 2'd0, 32'h0); #1;
    nxt(); #1;
    chk("wrh_hwdata", bus.hwdata, 32'h1234_0000);
    nxt(); #1;
    chk("wrh_rsp_valid", rsp_valid, 1);
    // Back-to-back reads 0x4 / 0x6 / 0x8
    nxt(); cmd(1, 0, REG_STATUS, 2'd1, 32'h0); #1;
    chk("b2b_ready0", cmd_ready, 1);
    nxt(); cmd(1, 0, REG_ERROR, 2'd1, 32'h0); #1;
    chk("b2b_c1_htrans", bus.htrans, HTRANS_NONSEQ);
    chk("b2b_c1_haddr", bus.haddr, 4'h4);
    chk("b2b_ready1", cmd_ready, 1);
    nxt(); cmd(1, 0, REG_OCC, 2'd2, 32'h0); bus.hrdata = 32'h1111_2222; #1;
    chk("b2b_c2_htrans", bus.htrans, HTRANS_NONSEQ);
    chk("b2b_c2_haddr", bus.haddr, 4'h6);
    chk("b2b_ready2", cmd_ready, 1);
    nxt(); cmd(0, 0, 4'h0, 2'd0, 32'h0); bus.hrdata = 32'h3333_4444; #1;
    chk("b2b_c3_htrans", bus.htrans, HTRANS_NONSEQ);
    chk("b2b_c3_haddr", bus.haddr, 4'h8);
    chk("b2b_c3_rsp_valid", rsp_valid, 1);
    chk("b2b_c3_rsp_rdata", rsp_rdata, 32'h0000_2222);
    nxt(); bus.hrdata = 32'h5555_6666; #1;
    chk("b2b_c4_htrans", bus.htrans, HTRANS_IDLE);
    chk("b2b_c4_rsp_valid", rsp_valid, 1);
    chk("b2b_c4_rsp_rdata", rsp_rdata, 32'h0000_3333);
    nxt(); #1;
    chk("b2b_c5_rsp_valid", rsp_valid, 1);
    chk("b2b_c5_rsp_rdata", rsp_rdata, 32'h5555_6666);
    nxt(); #1;
    chk("b2b_c6_rsp_valid", rsp_valid, 0);
    // Two-cycle hready stall during the data phase of 0x8, with 0x0 in address phase
    cmd(1, 0, REG_OCC, 2'd2, 32'h0); #1;
    nxt(); cmd(1, 0, REG_BUF, 2'd2, 32'h0); #1;
    chk("stl_ready1", cmd_ready, 1);
    nxt(); cmd(1, 0, REG_STATUS, 2'd2, 32'h0); bus.hready = 1'b0; #1;
    chk("stl_c2_ready", cmd_ready, 0);
    chk("stl_c2_haddr", bus.haddr, 4'h0);
    chk("stl_c2_htrans", bus.htrans, HTRANS_NONSEQ);
    nxt(); #1;
    chk("stl_c3_ready", cmd_ready, 0);
    chk("stl_c3_haddr", bus.haddr, 4'h0);
    chk("stl_c3_htrans", bus.htrans, HTRANS_NONSEQ);
    chk("stl_c3_rsp_valid", rsp_valid, 0);
    nxt(); bus.hready = 1'b1; bus.hrdata = 32'hCAFE_F00D; #1;
    chk("stl_c4_ready", cmd_ready, 1);
    chk("stl_c4_rsp_valid", rsp_valid, 0);
    nxt(); cmd(0, 0, 4'h0, 2'd0, 32'h0); bus.hrdata = 32'h0BAD_0001; #1;
    chk("stl_c5_rsp_valid", rsp_valid, 1);
    chk("stl_c5_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
    chk("stl_c5_haddr", bus.haddr, 4'h4);
    nxt(); bus.hrdata = 32'h0000_0042; #1;
    chk("stl_c6_rsp_rdata", rsp_rdata, 32'h0BAD_0001);
    chk("stl_c6_htrans", bus.htrans, HTRANS_IDLE);
    nxt(); #1;
    chk("stl_c7_rsp_rdata", rsp_rdata, 32'h0000_0042);
    // ERROR on write to 0xC with a read of 0xD in the address phase
    nxt(); cmd(1, 1, REG_TXCTL, 2'd2, 32'h0000_0001); #1;
    nxt(); cmd(1, 0, REG_FLUSH, 2'd0, 32'h0); #1;
    chk("err_c1_haddr", bus.haddr, 4'hC);
    chk("err_ready1", cmd_ready, 1);
    nxt(); cmd(0, 0, REG_FLUSH, 2'd0, 32'h0); bus.hresp = 1'b1; bus.hready = 1'b0; #1;
    chk("err_c2_haddr", bus.haddr, 4'hD);
    chk("err_c2_htrans", bus.htrans, HTRANS_NONSEQ);
    chk("err_c2_ready", cmd_ready, 0);
    nxt(); bus.hready = 1'b1; #1;
    chk("err_c3_htrans", bus.htrans, HTRANS_IDLE);
    chk("err_c3_ready", cmd_ready, 0);
    chk("err_c3_rsp_valid", rsp_valid, 0);
    nxt(); bus.hresp = 1'b0; #1;
    chk("err_c4_rsp_valid", rsp_valid, 1);
    chk("err_c4_rsp_err", rsp_err, 1);
    chk("err_c4_rsp_rdata", rsp_rdata, 0);
    chk("err_c4_htrans", bus.htrans, HTRANS_IDLE);
    chk("err_c4_ready", cmd_ready, 0);
    nxt(); #1;
    chk("err_c5_rsp_valid", rsp_valid, 1);
    chk("err_c5_rsp_err", rsp_err, 1);
    chk("err_c5_htrans", bus.htrans, HTRANS_IDLE);
    chk("err_c5_ready", cmd_ready, 1);
    nxt(); #1;
    chk("err_c6_rsp_valid", rsp_valid, 0);
    // Misaligned word read at 0x2, pipeline empty
    cmd(1, 0, 4'h2, 2'd2, 32'h0); #1;
    chk("mis_ready", cmd_ready, 1);
    nxt(); cmd(0, 0, 4'h0, 2'd0, 32'h0); #1;
    chk("mis_c1_htrans", bus.htrans, HTRANS_IDLE);
    chk("mis_c1_rsp_valid", rsp_valid, 1);
    chk("mis_c1_rsp_err", rsp_err, 1);
    nxt(); #1;
    chk("mis_c2_rsp_valid", rsp_valid, 0);
    // Illegal size held off until the aligned read ahead of it drains
    cmd(1, 0, REG_BUF, 2'd2, 32'h0); #1;
    nxt(); cmd(1, 0, REG_BUF, 2'd3, 32'h0); #1;
    chk("ill_c1_ready", cmd_ready, 0);
    chk("ill_c1_htrans", bus.htrans, HTRANS_NONSEQ);
    nxt(); bus.hrdata = 32'h0000_0077; #1;
    chk("ill_c2_ready", cmd_ready, 0);
    nxt(); #1;
    chk("ill_c3_ready", cmd_ready, 1);
    chk("ill_c3_rsp_valid", rsp_valid, 1);
    chk("ill_c3_rsp_err", rsp_err, 0);
    chk("ill_c3_rsp_rdata", rsp_rdata, 32'h0000_0077);
    nxt(); cmd(0, 0, 4'h0, 2'd0, 32'h0); #1;
    chk("ill_c4_rsp_valid", rsp_valid, 1);
    chk("ill_c4_rsp_err", rsp_err, 1);
    chk("ill_c4_htrans", bus.htrans, HTRANS_IDLE);
    // Reset during a stalled data phase drops the write
    nxt(); cmd(1, 1, REG_OCC, 2'd2, 32'h55AA_55AA); #1;
    nxt(); cmd(0, 0, 4'h0, 2'd0, 32'h0); #1;
    chk("rs_c1_htrans", bus.htrans, HTRANS_NONSEQ);
    nxt(); bus.hready = 1'b0; #1;
    chk("rs_c2_hwdata", bus.hwdata, 32'h55AA_55AA);
    rst = 1'b1;
    nxt(); #1;
    chk("rs_htrans", bus.htrans, HTRANS_IDLE);
    chk("rs_haddr", bus.haddr, 0);
    chk("rs_hsize", bus.hsize, 0);
    chk("rs_hwrite", bus.hwrite, 0);
    chk("rs_hwdata", bus.hwdata, 0);
    chk("rs_rsp_valid", rsp_valid, 0);
    chk("rs_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    bus.hready = 1'b1;
    nxt(); #1;
    chk("rs_c4_rsp_valid", rsp_valid, 0);
    chk("rs_c4_ready", cmd_ready, 1);
    nxt(); #1;
    chk("rs_c5_rsp_valid", rsp_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
